// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for the tapped-delay-line TDC: arm, coarse count, settle, fine decode, result handshake.
// Optional continuous mode: define TDC_AUTO_REARM_EN to re-arm directly after each accepted result.
module tdc_meas_ctrl #(
   parameter int          COARSE_W   = 16,
   parameter int          SETTLE_CYC = 2,
   parameter int unsigned TIMEOUT    = 32'hFFF0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic                edge_pol_i,
   input  logic                abort_i,
   input  logic                hit_i,
   input  logic [7:0]          fine_i,
   output logic                cap_en_o,
   output logic                shift_o,
   output logic                busy_o,
   output logic                m_valid_o,
   input  logic                m_ready_i,
   output logic [COARSE_W-1:0] m_coarse_o,
   output logic [7:0]          m_fine_o,
   output logic                m_err_o,
   output logic                m_tmo_o
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ARMED  = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_DECODE = 3'd3;
   localparam logic [2:0] S_OUT    = 3'd4;

   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SW-1:0]       SETTLE_LAST = SW'(SETTLE_CYC - 1);
   localparam logic [COARSE_W-1:0] TMO_LAST    = COARSE_W'(TIMEOUT - 1);
   localparam logic [COARSE_W-1:0] TMO_VAL     = COARSE_W'(TIMEOUT);

   logic [2:0]          state_q, state_d;
   logic [COARSE_W-1:0] cnt_q, cnt_d;
   logic [SW-1:0]       settle_q, settle_d;
   logic                shift_q, shift_d;
   logic [COARSE_W-1:0] coarse_q, coarse_d;
   logic [7:0]          fine_q, fine_d;
   logic                err_q, err_d;
   logic                tmo_q, tmo_d;
   logic                cap_en_q, busy_q, valid_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      settle_d = settle_q;
      shift_d  = shift_q;
      coarse_d = coarse_q;
      fine_d   = fine_q;
      err_d    = err_q;
      tmo_d    = tmo_q;
      if (abort_i) begin
         state_d = S_IDLE;
         err_d   = 1'b0;
         tmo_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  shift_d = edge_pol_i;
                  cnt_d   = '0;
                  state_d = S_ARMED;
               end
            end
            S_ARMED: begin
               // A hit on the timeout cycle wins over the timeout.
               if (hit_i) begin
                  coarse_d = cnt_q;
                  tmo_d    = 1'b0;
                  err_d    = 1'b0;
                  settle_d = '0;
                  state_d  = S_SETTLE;
               end else if (cnt_q == TMO_LAST) begin
                  coarse_d = TMO_VAL;
                  fine_d   = 8'hFF;
                  tmo_d    = 1'b1;
                  err_d    = 1'b0;
                  state_d  = S_OUT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_SETTLE: begin
               settle_d = settle_q + 1'b1;
               if (settle_q == SETTLE_LAST) begin
                  state_d = S_DECODE;
               end
            end
            S_DECODE: begin
               fine_d  = fine_i;
               err_d   = (fine_i == 8'hFF);
               state_d = S_OUT;
            end
            S_OUT: begin
               if (m_ready_i) begin
`ifdef TDC_AUTO_REARM_EN
                  cnt_d   = '0;
                  state_d = S_ARMED;
`else
                  state_d = S_IDLE;
`endif
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Status outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         settle_q <= '0;
         shift_q  <= 1'b0;
         coarse_q <= '0;
         fine_q   <= '0;
         err_q    <= 1'b0;
         tmo_q    <= 1'b0;
         cap_en_q <= 1'b0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         settle_q <= settle_d;
         shift_q  <= shift_d;
         coarse_q <= coarse_d;
         fine_q   <= fine_d;
         err_q    <= err_d;
         tmo_q    <= tmo_d;
         cap_en_q <= (state_d == S_ARMED);
         busy_q   <= (state_d != S_IDLE);
         valid_q  <= (state_d == S_OUT);
      end
   end

   assign cap_en_o   = cap_en_q;
   assign shift_o    = shift_q;
   assign busy_o     = busy_q;
   assign m_valid_o  = valid_q;
   assign m_coarse_o = coarse_q;
   assign m_fine_o   = fine_q;
   assign m_err_o    = err_q;
   assign m_tmo_o    = tmo_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl (SETTLE_CYC=2, TIMEOUT=8); continuous-mode section under TDC_AUTO_REARM_EN.
module tb_tdc_meas_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i, edge_pol_i, abort_i, hit_i, m_ready_i;
   logic [7:0]  fine_i;
   logic        cap_en_o, shift_o, busy_o, m_valid_o, m_err_o, m_tmo_o;
   logic [15:0] m_coarse_o;
   logic [7:0]  m_fine_o;

   int errors = 0;
   int checks = 0;
   int vcount;

   tdc_meas_ctrl #(.COARSE_W(16), .SETTLE_CYC(2), .TIMEOUT(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .edge_pol_i (edge_pol_i),
      .abort_i    (abort_i),
      .hit_i      (hit_i),
      .fine_i     (fine_i),
      .cap_en_o   (cap_en_o),
      .shift_o    (shift_o),
      .busy_o     (busy_o),
      .m_valid_o  (m_valid_o),
      .m_ready_i  (m_ready_i),
      .m_coarse_o (m_coarse_o),
      .m_fine_o   (m_fine_o),
      .m_err_o    (m_err_o),
      .m_tmo_o    (m_tmo_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst = 1'b1; start_i = 0; edge_pol_i = 0; abort_i = 0; hit_i = 0;
      m_ready_i = 0; fine_i = 8'd0;
      ticks(3);
      rst = 1'b0;
      tick();
      check("rst_busy",   busy_o,     0);
      check("rst_valid",  m_valid_o,  0);
      check("rst_cap",    cap_en_o,   0);
      check("rst_shift",  shift_o,    0);
      check("rst_coarse", m_coarse_o, 0);
      check("rst_fine",   m_fine_o,   0);

      // Basic: start at cycle 0, hit at cycle 6, fine sampled in cycle 9, result in cycle 10
      m_ready_i = 1; fine_i = 8'd99;
      start_i = 1; edge_pol_i = 1;
      tick();
      start_i = 0; edge_pol_i = 0;
      check("start_cap",   cap_en_o, 1);
      check("start_busy",  busy_o,   1);
      check("start_shift", shift_o,  1);
      ticks(5);
      hit_i = 1;
      tick();
      hit_i = 0;
      check("hit_cap_drop", cap_en_o, 0);
      ticks(2);
      fine_i = 8'd37;
      tick();
      fine_i = 8'd99;
      check("b_valid",  m_valid_o,  1);
      check("b_coarse", m_coarse_o, 5);
      check("b_fine",   m_fine_o,   37);
      check("b_err",    m_err_o,    0);
      check("b_tmo",    m_tmo_o,    0);
      tick();
      check("b_valid_once", m_valid_o, 0);
      check("b_idle",       busy_o,    0);
      check("b_shift_hold", shift_o,   1);

      // Backpressure: coarse 2, five cycles of ready low in OUT
      m_ready_i = 0; fine_i = 8'h55;
      start_i = 1;
      tick();
      start_i = 0;
      ticks(2);
      hit_i = 1;
      tick();
      hit_i = 0;
      ticks(3);
      fine_i = 8'hA0;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid",  m_valid_o,  1);
         check("bp_coarse", m_coarse_o, 2);
         check("bp_fine",   m_fine_o,   8'h55);
         tick();
      end
      m_ready_i = 1;
      check("bp_valid_last", m_valid_o, 1);
      tick();
      check("bp_accept", m_valid_o, 0);
      vcount = 0;
      for (int i = 0; i < 4; i++) begin
         if (m_valid_o) vcount++;
         tick();
      end
      check("bp_no_dup", vcount, 0);

      // Decoder miss: hit in first ARMED cycle, fine 8'hFF
      fine_i = 8'hFF;
      start_i = 1; edge_pol_i = 0;
      tick();
      start_i = 0;
      hit_i = 1;
      tick();
      hit_i = 0;
      ticks(3);
      check("miss_valid",  m_valid_o,  1);
      check("miss_err",    m_err_o,    1);
      check("miss_fine",   m_fine_o,   8'hFF);
      check("miss_tmo",    m_tmo_o,    0);
      check("miss_coarse", m_coarse_o, 0);
      check("miss_shift",  shift_o,    0);
      tick();

      // Timeout with no hit
      fine_i = 8'h12;
      start_i = 1;
      tick();
      start_i = 0;
      ticks(7);
      check("tmo_pre_valid", m_valid_o, 0);
      check("tmo_pre_cap",   cap_en_o,  1);
      tick();
      check("tmo_valid",  m_valid_o,  1);
      check("tmo_flag",   m_tmo_o,    1);
      check("tmo_coarse", m_coarse_o, 8);
      check("tmo_fine",   m_fine_o,   8'hFF);
      check("tmo_err",    m_err_o,    0);
      tick();

      // Hit on the last ARMED cycle beats the timeout
      start_i = 1;
      tick();
      start_i = 0;
      ticks(7);
      hit_i = 1;
      tick();
      hit_i = 0;
      ticks(3);
      check("tmh_valid",  m_valid_o,  1);
      check("tmh_tmo",    m_tmo_o,    0);
      check("tmh_coarse", m_coarse_o, 7);
      check("tmh_fine",   m_fine_o,   8'h12);
      tick();

      // Abort in SETTLE together with ready
      start_i = 1;
      tick();
      start_i = 0;
      hit_i = 1;
      tick();
      hit_i = 0;
      abort_i = 1; m_ready_i = 1;
      tick();
      abort_i = 0;
      check("abort_busy",  busy_o,    0);
      check("abort_valid", m_valid_o, 0);
      check("abort_cap",   cap_en_o,  0);
      vcount = 0;
      for (int i = 0; i < 6; i++) begin
         if (m_valid_o) vcount++;
         tick();
      end
      check("abort_no_valid", vcount, 0);

`ifdef TDC_AUTO_REARM_EN
      // Continuous mode: three results from one start, polarity toggled after start
      fine_i = 8'd20;
      start_i = 1; edge_pol_i = 1;
      tick();
      start_i = 0; edge_pol_i = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         hit_i = 1;
         tick();
         hit_i = 0;
         ticks(3);
         check("ra_valid",  m_valid_o,  1);
         check("ra_coarse", m_coarse_o, 1);
         tick();
         check("ra_cap",   cap_en_o, 1);
         check("ra_shift", shift_o,  1);
      end
      abort_i = 1;
      tick();
      abort_i = 0;
      check("ra_abort_busy", busy_o, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tdc_meas_ctrl.md
# tdc_meas_ctrl

Measurement sequencer for the tapped-delay-line TDC. Arms the delay-line sampler on a start request and runs a coarse clock-cycle counter. On a hit it freezes the counter and waits for the sampled thermometer code to settle. It then reads the fine bin from the combinational decoder and presents a {coarse, fine, flags} result on a valid/ready output port. It sits between the delay-line capture register / `tdc_decoder` and the readout FIFO.

## Interface
Parameters:
- `COARSE_W`, 16: coarse counter width.
- `SETTLE_CYC`, 2: cycles between hit and fine sample (≥1); covers the metastability flops on the chain.
- `TIMEOUT`, 16'hFFF0: coarse count at which an armed measurement with no hit is abandoned. Must satisfy 1 ≤ `TIMEOUT` ≤ 2^`COARSE_W`−1.

Ports:
- `clk`, in, 1: single clock for all logic.
- `rst`, in, 1: synchronous, active-high reset.
- `start_i`, in, 1: arm request; sampled in IDLE only.
- `edge_pol_i`, in, 1: transition polarity for the decoder; latched on start.
- `abort_i`, in, 1: cancel the measurement from any state.
- `hit_i`, in, 1: synchronized stop-event pulse.
- `fine_i`, in, 8: decoder bin; 8'hFF means no transition found.
- `cap_en_o`, out, 1: enable for the delay-line sampling register.
- `shift_o`, out, 1: drives the decoder `shift` input.
- `busy_o`, out, 1: high in any state except IDLE.
- `m_valid_o`, out, 1: result valid.
- `m_ready_i`, in, 1: result accepted by the sink.
- `m_coarse_o`, out, `COARSE_W`: coarse count.
- `m_fine_o`, out, 8: fine bin.
- `m_err_o`, out, 1: decoder returned 8'hFF.
- `m_tmo_o`, out, 1: timeout, no hit.

## Operation
- FSM states: IDLE, ARMED, SETTLE, DECODE, OUT.
- IDLE: waits for `start_i`. On `start_i`: latch `edge_pol_i` into `shift_o`, clear `coarse_cnt`, go to ARMED.
- ARMED: `cap_en_o`=1; `coarse_cnt` increments every cycle, starting at 0 in the first ARMED cycle.
  - `hit_i`=1: capture the current `coarse_cnt` into `m_coarse_o`, drop `cap_en_o` next cycle, go to SETTLE.
  - No hit and `coarse_cnt`==`TIMEOUT`−1: set `m_coarse_o`=`TIMEOUT`, `m_fine_o`=8'hFF, `m_tmo_o`=1, go to OUT.
  - Hit on the timeout cycle: the hit wins; `m_tmo_o`=0.
- SETTLE: counts `SETTLE_CYC`−1 cycles, then goes to DECODE.
- DECODE: one cycle.
  - Register `fine_i` into `m_fine_o`.
  - `m_err_o`=(`fine_i`==8'hFF).
  - Go to OUT.
- OUT: `m_valid_o`=1; all `m_*` outputs held stable until `m_valid_o`&`m_ready_i`.
  - On that handshake go to IDLE, or re-arm per Configuration.
- `start_i` and `hit_i` are ignored outside IDLE and ARMED respectively.
- `abort_i`: from any state, go to IDLE next cycle and clear `m_valid_o`, `cap_en_o`, `m_tmo_o`, `m_err_o`.
  - `abort_i` has priority over hit, timeout and handshake in the same cycle.
- `coarse_cnt` never wraps; the timeout bound is checked before any wrap can occur.
- `shift_o` holds its latched value until the next start.

## Timing
- Reset values: all outputs 0, `m_fine_o`=0, FSM in IDLE, `coarse_cnt`=0.
- Start latency: `start_i` at cycle t → `cap_en_o`=1 and `busy_o`=1 at t+1.
- Hit latency: hit at cycle h → `m_valid_o`=1 at h+`SETTLE_CYC`+2.
  - `fine_i` is sampled in cycle h+`SETTLE_CYC`+1.
  - `fine_i` must reflect the frozen capture register by then.
- Back-to-back measurements in non-re-arm mode: one IDLE cycle is inserted after acceptance.
- `m_ready_i` may be high before `m_valid_o`; acceptance occurs in the first cycle where both are high.
- Reset mid-measurement behaves as an abort and also clears `shift_o` and all data outputs.

## Configuration
- `TDC_AUTO_REARM_EN` defined: after the OUT handshake, go directly to ARMED.
  - `coarse_cnt` is cleared; `shift_o` is kept.
  - `cap_en_o` reasserts the cycle after acceptance, giving continuous measurement.
  - `abort_i` is the only exit to IDLE.
- `TDC_AUTO_REARM_EN` undefined: return to IDLE after every accepted result; a new `start_i` is required.

## Test plan
- Basic measurement (`SETTLE_CYC`=2, `m_ready_i`=1):
  - Stimulus: `start_i` at t=0, `hit_i` at t=6, `fine_i`=8'd37.
  - Required: `m_coarse_o`=5, `m_fine_o`=37, `m_valid_o` for one cycle at t=10, then IDLE.
- Backpressure: hold `m_ready_i`=0 for 5 cycles in OUT.
  - Required: outputs stable throughout, single acceptance when ready rises, no duplicate valid.
- Decoder miss: `fine_i`=8'hFF at the DECODE sample.
  - Required: `m_err_o`=1, `m_fine_o`=8'hFF, `m_tmo_o`=0.
- Timeout (`TIMEOUT`=8), no hit.
  - Required: `m_tmo_o`=1, `m_coarse_o`=8, `m_fine_o`=8'hFF.
  - Repeat with `hit_i` on the last ARMED cycle: `m_tmo_o`=0, `m_coarse_o`=7.
- Abort: `abort_i` asserted in SETTLE together with `m_ready_i`.
  - Required: IDLE next cycle, `m_valid_o` never asserts, `busy_o`=0.
- With `TDC_AUTO_REARM_EN`: three hits without a new start, with `edge_pol_i` toggled after the first start.
  - Required: three results, `shift_o` unchanged, `cap_en_o` reasserted the cycle after each acceptance.
